// File: rtl/ndma_write_mgr.sv
// NanoDMA write-side manager: buffers read-side words in a FIFO and
// writes them over OBI to consecutive word addresses.
module ndma_write_mgr #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [31:0]      dst_addr_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             wvalid_i,
  input  logic [31:0]      wdata_i,
  output logic             wready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             write_mgr_req,
  input  logic             write_mgr_gnt,
  output logic [31:0]      write_mgr_addr,
  output logic             write_mgr_we,
  output logic [3:0]       write_mgr_be,
  output logic [31:0]      write_mgr_wdata,
  input  logic             write_mgr_rvalid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic [31:0]      mem [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [PW:0]      cnt_q;
  logic [31:0]      addr_q;
  logic [LEN_W-1:0] len_q, rem_q, acc_q;
  logic             done_q;

  logic busy, full, empty;
  logic push, pop, cap;
  logic rsp, fin, zero_done, req;

  assign busy  = (state_q != IDLE);
  assign full  = (cnt_q == CNT_FULL);
  assign empty = (cnt_q == '0);

  assign wready_o = busy && !full && (acc_q < len_q);
  assign push     = wvalid_i && wready_o;

  assign busy_o = busy;
  assign done_o = done_q;

  assign write_mgr_req   = req;
  assign write_mgr_addr  = addr_q;
  assign write_mgr_we    = 1'b1;
  assign write_mgr_be    = 4'hF;
  assign write_mgr_wdata = mem[rptr_q];

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    state_d   = state_q;
    req       = 1'b0;
    pop       = 1'b0;
    cap       = 1'b0;
    rsp       = 1'b0;
    fin       = 1'b0;
    zero_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            cap     = 1'b1;
            state_d = REQ;
          end else begin
            zero_done = 1'b1;
          end
        end
      end
      REQ: begin
        req = !empty;
        if (req && write_mgr_gnt) begin
          pop     = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (write_mgr_rvalid) begin
          rsp = 1'b1;
          if (rem_q == LEN_W'(1)) begin
            fin     = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Address, length and word counters plus done pulse
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      addr_q <= '0;
      len_q  <= '0;
      rem_q  <= '0;
      acc_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= fin | zero_done;
      if (cap) begin
        addr_q <= dst_addr_i & 32'hFFFF_FFFC;
        len_q  <= len_i;
        rem_q  <= len_i;
        acc_q  <= '0;
      end else begin
        if (pop)  addr_q <= addr_q + 32'd4;
        if (rsp)  rem_q  <= rem_q - LEN_W'(1);
        if (push) acc_q  <= acc_q + LEN_W'(1);
      end
    end
  end

  // FIFO storage; contents need no reset since count gates use
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr_q] <= wdata_i;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_ndma_write_mgr.sv
// Randomized bench for ndma_write_mgr against a queue-based
// transfer model, plus directed scenarios with literal checks.
module tb_ndma_write_mgr;

  localparam int DEPTH = 4;
  localparam int LEN_W = 16;

  logic             clk;
  logic             rst_ni;
  logic             start_i;
  logic [31:0]      dst_addr_i;
  logic [LEN_W-1:0] len_i;
  logic             wvalid_i;
  logic [31:0]      wdata_i;
  logic             wready_o;
  logic             busy_o;
  logic             done_o;
  logic             write_mgr_req;
  logic             write_mgr_gnt;
  logic [31:0]      write_mgr_addr;
  logic             write_mgr_we;
  logic [3:0]       write_mgr_be;
  logic [31:0]      write_mgr_wdata;
  logic             write_mgr_rvalid;

  ndma_write_mgr #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .start_i          (start_i),
    .dst_addr_i       (dst_addr_i),
    .len_i            (len_i),
    .wvalid_i         (wvalid_i),
    .wdata_i          (wdata_i),
    .wready_o         (wready_o),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .write_mgr_req    (write_mgr_req),
    .write_mgr_gnt    (write_mgr_gnt),
    .write_mgr_addr   (write_mgr_addr),
    .write_mgr_we     (write_mgr_we),
    .write_mgr_be     (write_mgr_be),
    .write_mgr_wdata  (write_mgr_wdata),
    .write_mgr_rvalid (write_mgr_rvalid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;
  int n_busy = 0;
  int n_push = 0;

  int p_w = 100;
  int p_g = 100;
  int p_r = 100;

  logic [31:0] src_q[$];
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];

  // transfer model
  bit          m_busy = 0;
  bit          m_done = 0;
  bit          m_out = 0;
  int          m_len = 0;
  int          m_rem = 0;
  int          m_acc = 0;
  logic [31:0] m_addr = 0;
  logic [31:0] m_fifo[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %08h want %08h at %0t",
                 nm, act, exp, $time);
    end
  endtask

  // per-cycle compare against the model, then advance the model
  initial begin : mon
    bit e_wr, e_rq, nd;
    forever begin
      @(negedge clk);
      e_wr = m_busy && (m_fifo.size() < DEPTH) && (m_acc < m_len);
      e_rq = m_busy && !m_out && (m_fifo.size() != 0);
      chk("busy_o", 32'(busy_o), 32'(m_busy));
      chk("done_o", 32'(done_o), 32'(m_done));
      chk("wready_o", 32'(wready_o), 32'(e_wr));
      chk("req", 32'(write_mgr_req), 32'(e_rq));
      chk("addr", write_mgr_addr, m_addr);
      chk("we", 32'(write_mgr_we), 32'd1);
      chk("be", 32'(write_mgr_be), 32'hF);
      if (e_rq) chk("wdata", write_mgr_wdata, m_fifo[0]);
      if (done_o) n_done++;
      if (busy_o) n_busy++;
      if (wvalid_i && wready_o) n_push++;
      if (write_mgr_req && write_mgr_gnt) begin
        log_addr.push_back(write_mgr_addr);
        log_data.push_back(write_mgr_wdata);
      end
      if (!rst_ni) begin
        m_busy = 0; m_done = 0; m_out = 0;
        m_len = 0; m_rem = 0; m_acc = 0;
        m_addr = 0;
        m_fifo.delete();
      end else begin
        nd = 0;
        if (!m_busy) begin
          if (start_i) begin
            if (len_i == 0) nd = 1;
            else begin
              m_busy = 1;
              m_len = int'(len_i);
              m_rem = int'(len_i);
              m_acc = 0;
              m_addr = dst_addr_i & 32'hFFFF_FFFC;
            end
          end
        end else begin
          if (e_rq && write_mgr_gnt) begin
            void'(m_fifo.pop_front());
            m_addr = m_addr + 32'd4;
            m_out = 1;
          end else if (m_out && write_mgr_rvalid) begin
            m_out = 0;
            m_rem--;
            if (m_rem == 0) begin
              m_busy = 0;
              nd = 1;
            end
          end
          if (wvalid_i && e_wr) begin
            m_fifo.push_back(wdata_i);
            m_acc++;
          end
        end
        m_done = nd;
      end
    end
  end

  // read-side source and OBI slave responder
  initial begin : drv
    bit fire;
    wvalid_i = 0;
    wdata_i = 0;
    write_mgr_gnt = 0;
    write_mgr_rvalid = 0;
    forever begin
      @(negedge clk);
      fire = wvalid_i && wready_o;
      @(posedge clk);
      #1;
      if (fire && src_q.size() > 0) void'(src_q.pop_front());
      wvalid_i = (src_q.size() > 0) && ($urandom_range(0, 99) < p_w);
      wdata_i = (src_q.size() > 0) ? src_q[0] : $urandom;
      write_mgr_gnt = ($urandom_range(0, 99) < p_g);
      write_mgr_rvalid = ($urandom_range(0, 99) < p_r);
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic do_start(input logic [31:0] a, input int n);
    @(posedge clk);
    #1;
    start_i = 1;
    dst_addr_i = a;
    len_i = LEN_W'(n);
    @(posedge clk);
    #1;
    start_i = 0;
    dst_addr_i = $urandom;
    len_i = LEN_W'($urandom);
  endtask

  task automatic wait_done(input int max, input string nm);
    int d0;
    d0 = n_done;
    for (int i = 0; i < max; i++) begin
      @(posedge clk);
      if (n_done != d0) break;
    end
    chk(nm, 32'(n_done != d0), 32'd1);
    tick(1);
  endtask

  task automatic clr_log();
    log_addr.delete();
    log_data.delete();
  endtask

  initial begin : main
    int d0, b0, p0, len;
    logic [31:0] a, base;
    logic [31:0] words[$];
    rst_ni = 0;
    start_i = 0;
    dst_addr_i = 0;
    len_i = 0;
    tick(2);
    rst_ni = 1;
    @(negedge clk);
    chk("rst busy", 32'(busy_o), 0);
    chk("rst wready", 32'(wready_o), 0);
    chk("rst req", 32'(write_mgr_req), 0);
    chk("rst addr", write_mgr_addr, 0);
    chk("rst done", 32'(done_o), 0);

    // basic transfer, zero wait states
    tick(1);
    clr_log();
    for (int i = 0; i < 4; i++) src_q.push_back(32'hA0 + 32'(i));
    d0 = n_done;
    do_start(32'h1000, 4);
    wait_done(200, "basic done");
    tick(3);
    chk("basic count", 32'(log_addr.size()), 4);
    chk("basic ndone", 32'(n_done - d0), 1);
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      chk("basic addr", log_addr[i], 32'h1000 + 32'(4 * i));
      chk("basic data", log_data[i], 32'hA0 + 32'(i));
    end

    // backpressure with grant held low
    clr_log();
    for (int i = 0; i < 8; i++) src_q.push_back(32'hB0 + 32'(i));
    p_g = 0;
    p0 = n_push;
    do_start(32'h2000, 8);
    tick(10);
    @(negedge clk);
    chk("bp pushes", 32'(n_push - p0), 4);
    chk("bp wready", 32'(wready_o), 0);
    chk("bp req", 32'(write_mgr_req), 1);
    chk("bp addr", write_mgr_addr, 32'h2000);
    chk("bp wdata", write_mgr_wdata, 32'hB0);
    p_g = 100;
    wait_done(400, "bp done");
    chk("bp count", 32'(log_addr.size()), 8);
    for (int i = 0; i < 8 && i < log_addr.size(); i++) begin
      chk("bp addr", log_addr[i], 32'h2000 + 32'(4 * i));
      chk("bp data", log_data[i], 32'hB0 + 32'(i));
    end

    // over-supply
    for (int i = 0; i < 6; i++) src_q.push_back(32'hC0 + 32'(i));
    p0 = n_push;
    do_start(32'h3000, 2);
    wait_done(200, "os done");
    tick(2);
    @(negedge clk);
    chk("os pushes", 32'(n_push - p0), 2);
    chk("os wready", 32'(wready_o), 0);
    tick(1);
    src_q.delete();
    tick(2);

    // zero length
    d0 = n_done;
    b0 = n_busy;
    do_start(32'h9000, 0);
    tick(3);
    chk("zl ndone", 32'(n_done - d0), 1);
    chk("zl busy", 32'(n_busy - b0), 0);

    // misaligned start, address wrap
    clr_log();
    for (int i = 0; i < 3; i++) src_q.push_back(32'hD0 + 32'(i));
    do_start(32'hFFFF_FFFB, 3);
    wait_done(200, "wrap done");
    chk("wrap count", 32'(log_addr.size()), 3);
    if (log_addr.size() == 3) begin
      chk("wrap a0", log_addr[0], 32'hFFFF_FFF8);
      chk("wrap a1", log_addr[1], 32'hFFFF_FFFC);
      chk("wrap a2", log_addr[2], 32'h0000_0000);
    end

    // start while busy, stray rvalid in REQ
    clr_log();
    for (int i = 0; i < 6; i++) src_q.push_back(32'hE0 + 32'(i));
    p_g = 50;
    p_r = 50;
    d0 = n_done;
    do_start(32'h4000, 6);
    tick(3);
    do_start(32'h5550_0000, 2);
    wait_done(600, "sb done");
    tick(3);
    chk("sb count", 32'(log_addr.size()), 6);
    chk("sb ndone", 32'(n_done - d0), 1);
    for (int i = 0; i < 6 && i < log_addr.size(); i++)
      chk("sb addr", log_addr[i], 32'h4000 + 32'(4 * i));

    // reset mid-transfer
    for (int i = 0; i < 8; i++) src_q.push_back(32'hF0 + 32'(i));
    p_g = 30;
    do_start(32'h6000, 8);
    tick(6);
    d0 = n_done;
    @(posedge clk);
    #1;
    rst_ni = 0;
    tick(1);
    src_q.delete();
    tick(1);
    rst_ni = 1;
    @(negedge clk);
    chk("mr busy", 32'(busy_o), 0);
    chk("mr req", 32'(write_mgr_req), 0);
    chk("mr wready", 32'(wready_o), 0);
    tick(4);
    chk("mr nodone", 32'(n_done - d0), 0);
    clr_log();
    p_g = 100;
    p_r = 100;
    src_q.push_back(32'h1234_5678);
    src_q.push_back(32'h9ABC_DEF0);
    do_start(32'h7000, 2);
    wait_done(200, "mr done");
    chk("mr count", 32'(log_addr.size()), 2);
    if (log_addr.size() == 2) begin
      chk("mr a0", log_addr[0], 32'h7000);
      chk("mr d0", log_data[0], 32'h1234_5678);
      chk("mr a1", log_addr[1], 32'h7004);
      chk("mr d1", log_data[1], 32'h9ABC_DEF0);
    end

    // randomized transfers
    for (int t = 0; t < 25; t++) begin
      clr_log();
      words.delete();
      len = $urandom_range(1, 12);
      a = $urandom;
      base = a & 32'hFFFF_FFFC;
      p_w = $urandom_range(30, 100);
      p_g = $urandom_range(30, 100);
      p_r = $urandom_range(30, 100);
      for (int i = 0; i < len + $urandom_range(0, 3); i++) begin
        words.push_back($urandom);
        src_q.push_back(words[i]);
      end
      do_start(a, len);
      wait_done(len * 80 + 100, "rnd done");
      chk("rnd count", 32'(log_addr.size()), 32'(len));
      for (int i = 0; i < len && i < log_addr.size(); i++) begin
        chk("rnd addr", log_addr[i], base + 32'(4 * i));
        chk("rnd data", log_data[i], words[i]);
      end
      tick(1);
      src_q.delete();
      tick(2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
